board_state_writer: RTL and testbench
=====================================

Name: board_state_writer

Overview:
- Write side of the board-state memory for the ultimate tic-tac-toe game.
- Accepts a committed move (macro cell, micro cell, player), stores the mark in an internal 81-cell micro-board array, and scans the affected micro board for a win or draw.
- Drives the macro board-state RAM write port (we/addr/data) with the micro board's outcome.
- Sits between the control unit (which issues the commit) and the board-state RAM that the datapath reads.

Parameters:
- N_CELLS, 9, cells per board; fixed at 9, not meant to be overridden.
- ADDR_W, 4, width of macro and micro cell indices.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- commit  in  1  one-cycle request to play; sampled only in IDLE
- jogador  in  1  current player: 0 = X, 1 = O
- macro_addr  in  4  macro board index, 0..8
- micro_addr  in  4  micro cell index, 0..8
- macro_we  out  1  write enable to the board-state RAM
- macro_wr_addr  out  4  board-state RAM address (the latched macro_addr)
- macro_wr_data  out  2  00 in progress, 01 X won, 10 O won, 11 draw
- resultado_micro  out  2  outcome of the last completed move's micro board, same encoding
- pronto  out  1  one-cycle pulse when a valid move is fully processed
- jogada_invalida  out  1  one-cycle pulse when a commit is rejected
- ocupado  out  1  high in every state except IDLE
- db_estado  out  4  FSM state code, for debug

Behaviour:
- Storage:
  - Cell array: 81 x 2 bits, mark encoding 00 empty, 01 X, 10 O.
  - Per-macro fill counter: 4 bits, range 0..9.
  - Per-macro decided flag: 9 bits.
- Reset values: all cells 00, counters 0, flags 0, FSM in IDLE, every output 0.
- FSM states and codes: IDLE=0, CHECK=1, WRITE=2, SCAN=3, UPDATE=4, DONE=5, REJECT=6.
- IDLE:
  - On commit=1, latch macro_addr, micro_addr and jogador, then go to CHECK.
  - commit in any other state is ignored and never queued.
- CHECK (1 cycle): go to REJECT if any of the following holds; otherwise go to WRITE.
  - macro_addr > 8 or micro_addr > 8
  - the target cell is not 00
  - the macro's decided flag is set
- REJECT (1 cycle): jogada_invalida=1, no array or RAM write, then IDLE.
- WRITE (1 cycle):
  - At the end of the cycle, write the mark (jogador ? 10 : 01) into the cell and increment that macro's fill counter.
  - Line index is cleared to 0.
- SCAN (exactly 8 cycles, line index 0..7):
  - Each cycle, compare the three cells of line L of the latched macro against the mark.
  - If all three are equal to the mark, set a sticky win flag.
  - All 8 lines are always scanned; there is no early exit.
  - After L=7, go to UPDATE.
- UPDATE (1 cycle), Moore outputs:
  - Win: macro_we=1, macro_wr_data=mark, set the decided flag.
  - Else, fill counter = 9: macro_we=1, macro_wr_data=11, set the decided flag.
  - Else: macro_we=0, macro_wr_data=00.
  - macro_wr_addr is the latched macro in every case.
  - resultado_micro is updated at the end of the cycle.
- DONE (1 cycle): pronto=1, then IDLE.
- Latency, with commit sampled at edge k:
  - macro_we is visible during cycle k+11.
  - pronto is high during cycle k+12.
  - A rejected commit pulses jogada_invalida during cycle k+2.
- Win takes priority over draw when the 9th mark also completes a line.
- Reset mid-operation: return to IDLE the next edge; any partially processed move issues no RAM write.
- If WRITE has already completed when reset arrives, reset still clears the array.
- Outside UPDATE, macro_we=0 and macro_wr_data=00.

Decomposition:
- Shared package:
  - Mark and result encodings (EMPTY, MARK_X, MARK_O, DRAW).
  - FSM state codes.
  - The 8-entry line table: {0,1,2}, {3,4,5}, {6,7,8}, {0,3,6}, {1,4,7}, {2,5,8}, {0,4,8}, {2,4,6}.
- One natural sub-module, line_checker (combinational):
  - Inputs: 18-bit micro board and a 3-bit line index.
  - Output: a 2-bit "line owner" (00 when no player owns the line).

Test Plan:
- X plays macro 4 at cells 0, 1, 2, with O moves in macro 0 interleaved -> after the third X move, macro_we=1 in UPDATE with addr=4, data=01; resultado_micro=01; pronto at commit+12.
- A further commit to macro 4, cell 5 -> jogada_invalida pulse at commit+2; no macro_we; cell array unchanged.
- Fill macro 2 with X:0,2,3,7,8 and O:1,4,5,6, where the last move (X@8) creates no line -> final UPDATE writes addr=2, data=11.
- 9th move completes a line, e.g. O takes cell 2 with O already holding cells 4 and 6 -> data=10, not 11.
- Commit to an occupied cell, micro_addr=9, and macro_addr=12 -> each pulses jogada_invalida; no writes.
- Commit pulse issued in SCAN -> ignored. Reset asserted in SCAN -> IDLE next cycle, no macro_we, all outputs 0, a replayed move on the same cell is accepted.

Source files
------------

// File: rtl/board_state_writer_pkg.sv
// Shared encodings, FSM codes and line table for the ultimate tic-tac-toe
// board-state writer.
package board_state_writer_pkg;

  localparam int N_CELLS = 9;
  localparam int ADDR_W  = 4;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;
  localparam logic [1:0] DRAW   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CHECK  = 4'd1,
    S_WRITE  = 4'd2,
    S_SCAN   = 4'd3,
    S_UPDATE = 4'd4,
    S_DONE   = 4'd5,
    S_REJECT = 4'd6
  } state_t;

  typedef logic [2*N_CELLS-1:0] board_t;

  // Three cell indices of a line, packed {first, second, third}.
  function automatic logic [3*ADDR_W-1:0] line_cells(input logic [2:0] line);
    logic [3*ADDR_W-1:0] cells;
    case (line)
      3'd0:    cells = {4'd0, 4'd1, 4'd2};
      3'd1:    cells = {4'd3, 4'd4, 4'd5};
      3'd2:    cells = {4'd6, 4'd7, 4'd8};
      3'd3:    cells = {4'd0, 4'd3, 4'd6};
      3'd4:    cells = {4'd1, 4'd4, 4'd7};
      3'd5:    cells = {4'd2, 4'd5, 4'd8};
      3'd6:    cells = {4'd0, 4'd4, 4'd8};
      default: cells = {4'd2, 4'd4, 4'd6};
    endcase
    return cells;
  endfunction

  function automatic logic [1:0] cell_of(input board_t board, input logic [ADDR_W-1:0] idx);
    logic [1:0] mark;
    mark = EMPTY;
    for (int i = 0; i < N_CELLS; i++) begin
      if (idx == ADDR_W'(i)) mark = board[2*i +: 2];
    end
    return mark;
  endfunction

endpackage

// File: rtl/board_state_writer_line_checker.sv
// Combinational owner of one line of a micro board: the common mark when all
// three cells hold the same player, EMPTY otherwise.
module line_checker
  import board_state_writer_pkg::*;
(
  input  logic [2*N_CELLS-1:0] i_board,
  input  logic [2:0]           i_line,
  output logic [1:0]           o_owner
);

  logic [3*ADDR_W-1:0] w_cells;
  logic [1:0]          w_a;
  logic [1:0]          w_b;
  logic [1:0]          w_c;

  assign w_cells = line_cells(i_line);
  assign w_a     = cell_of(i_board, w_cells[3*ADDR_W-1 -: ADDR_W]);
  assign w_b     = cell_of(i_board, w_cells[2*ADDR_W-1 -: ADDR_W]);
  assign w_c     = cell_of(i_board, w_cells[ADDR_W-1:0]);

  assign o_owner = (w_a != EMPTY && w_a == w_b && w_b == w_c) ? w_a : EMPTY;

endmodule

// File: rtl/board_state_writer.sv
// Write side of the ultimate tic-tac-toe board-state memory: validates and stores
// a move, scans its micro board line by line, and writes the outcome to the RAM.
module board_state_writer
  import board_state_writer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              commit,
  input  logic              jogador,
  input  logic [ADDR_W-1:0] macro_addr,
  input  logic [ADDR_W-1:0] micro_addr,
  output logic              macro_we,
  output logic [ADDR_W-1:0] macro_wr_addr,
  output logic [1:0]        macro_wr_data,
  output logic [1:0]        resultado_micro,
  output logic              pronto,
  output logic              jogada_invalida,
  output logic              ocupado,
  output logic [3:0]        db_estado
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_macro;
  logic [ADDR_W-1:0] r_micro;
  logic              r_player;
  logic [2:0]        r_line;
  logic              r_win;
  board_t            r_board [N_CELLS];
  logic [3:0]        r_fill  [N_CELLS];
  logic [N_CELLS-1:0] r_decided;
  logic [1:0]        r_result;

  logic              w_macro_ok;
  logic              w_micro_ok;
  logic [ADDR_W-1:0] w_macro_idx;
  board_t            w_board;
  logic [3:0]        w_fill;
  logic [1:0]        w_mark;
  logic              w_reject;
  logic [1:0]        w_owner;
  logic [1:0]        w_outcome;

  assign w_macro_ok  = r_macro < ADDR_W'(N_CELLS);
  assign w_micro_ok  = r_micro < ADDR_W'(N_CELLS);
  // Out-of-range macros are redirected to board 0 so no array read goes out of bounds.
  assign w_macro_idx = w_macro_ok ? r_macro : '0;
  assign w_board     = r_board[w_macro_idx];
  assign w_fill      = r_fill[w_macro_idx];
  assign w_mark      = r_player ? MARK_O : MARK_X;
  assign w_reject    = !w_macro_ok || !w_micro_ok
                    || (cell_of(w_board, r_micro) != EMPTY)
                    || r_decided[w_macro_idx];

  line_checker u_line_checker (
    .i_board (w_board),
    .i_line  (r_line),
    .o_owner (w_owner)
  );

  // A win outranks a draw when the ninth mark also closes a line.
  assign w_outcome = r_win ? w_mark : (w_fill == 4'd9) ? DRAW : EMPTY;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (commit) w_next = S_CHECK;
      S_CHECK:  w_next = w_reject ? S_REJECT : S_WRITE;
      S_WRITE:  w_next = S_SCAN;
      S_SCAN:   if (r_line == 3'd7) w_next = S_UPDATE;
      S_UPDATE: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      S_REJECT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign macro_we        = (r_state == S_UPDATE) && (w_outcome != EMPTY);
  assign macro_wr_data   = (r_state == S_UPDATE) ? w_outcome : EMPTY;
  assign macro_wr_addr   = r_macro;
  assign resultado_micro = r_result;
  assign pronto          = r_state == S_DONE;
  assign jogada_invalida = r_state == S_REJECT;
  assign ocupado         = r_state != S_IDLE;
  assign db_estado       = r_state;

  // NOTE: state uses non-blocking assignments so every register samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_macro   <= '0;
      r_micro   <= '0;
      r_player  <= 1'b0;
      r_line    <= '0;
      r_win     <= 1'b0;
      r_decided <= '0;
      r_result  <= EMPTY;
      // NOTE: the cell array is deliberately reset: a new game must start empty
      // and a half-played move must not survive reset.
      for (int i = 0; i < N_CELLS; i++) begin
        r_board[i] <= '0;
        r_fill[i]  <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (commit) begin
            r_macro  <= macro_addr;
            r_micro  <= micro_addr;
            r_player <= jogador;
          end
        end
        S_WRITE: begin
          for (int i = 0; i < N_CELLS; i++) begin
            if (r_micro == ADDR_W'(i)) r_board[w_macro_idx][2*i +: 2] <= w_mark;
          end
          r_fill[w_macro_idx] <= w_fill + 4'd1;
          r_line              <= '0;
          r_win               <= 1'b0;
        end
        S_SCAN: begin
          if (w_owner == w_mark) r_win <= 1'b1;
          r_line <= r_line + 3'd1;
        end
        S_UPDATE: begin
          if (w_outcome != EMPTY) r_decided[w_macro_idx] <= 1'b1;
          r_result <= w_outcome;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state_writer.sv
// Self-checking bench for board_state_writer: a game-level model predicts every
// output each cycle, and directed moves pin key results with literal values.
module tb_board_state_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       commit = 1'b0;
  logic       jogador = 1'b0;
  logic [3:0] macro_addr = '0;
  logic [3:0] micro_addr = '0;
  logic       macro_we;
  logic [3:0] macro_wr_addr;
  logic [1:0] macro_wr_data;
  logic [1:0] resultado_micro;
  logic       pronto;
  logic       jogada_invalida;
  logic       ocupado;
  logic [3:0] db_estado;

  board_state_writer dut (
    .clock           (clock),
    .reset           (reset),
    .commit          (commit),
    .jogador         (jogador),
    .macro_addr      (macro_addr),
    .micro_addr      (micro_addr),
    .macro_we        (macro_we),
    .macro_wr_addr   (macro_wr_addr),
    .macro_wr_data   (macro_wr_data),
    .resultado_micro (resultado_micro),
    .pronto          (pronto),
    .jogada_invalida (jogada_invalida),
    .ocupado         (ocupado),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: marks per cell, decided macros, and the timeline of the current move.
  int         m_cell [9][9];
  bit         m_dec  [9];
  int         lines  [8][3];
  bit         started = 1'b0;
  bit         active  = 1'b0;
  bit         op_valid;
  int         d;
  int         op_macro;
  logic [1:0] op_outcome;
  logic [1:0] shown_result = 2'b00;

  initial lines = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function void model_clear();
    for (int b = 0; b < 9; b++) begin
      m_dec[b] = 1'b0;
      for (int c = 0; c < 9; c++) m_cell[b][c] = 0;
    end
  endfunction

  function void start_op(int mac, int mic, int pl);
    int mark;
    int filled;
    bit win;
    op_macro   = mac;
    op_valid   = 1'b0;
    op_outcome = 2'b00;
    if (mac > 8 || mic > 8) return;
    if (m_cell[mac][mic] != 0) return;
    if (m_dec[mac]) return;
    op_valid = 1'b1;
    mark = pl ? 2 : 1;
    m_cell[mac][mic] = mark;
    filled = 0;
    for (int c = 0; c < 9; c++) if (m_cell[mac][c] != 0) filled++;
    win = 1'b0;
    for (int l = 0; l < 8; l++)
      if (m_cell[mac][lines[l][0]] == mark && m_cell[mac][lines[l][1]] == mark &&
          m_cell[mac][lines[l][2]] == mark) win = 1'b1;
    if (win) op_outcome = 2'(mark);
    else if (filled == 9) op_outcome = 2'b11;
    if (op_outcome != 2'b00) m_dec[mac] = 1'b1;
  endfunction

  // d counts cycles after the commit edge: 1 = check, 2 = write/reject, 11 = update, 12 = done.
  always @(posedge clock) begin
    if (reset) begin
      model_clear();
      started      = 1'b1;
      active       = 1'b0;
      d            = 0;
      shown_result = 2'b00;
    end else if (started) begin
      if (active) begin
        if ((op_valid && d == 12) || (!op_valid && d == 2)) active = 1'b0;
        else begin
          d++;
          if (op_valid && d == 12) shown_result = op_outcome;
        end
      end else if (commit) begin
        start_op(int'(macro_addr), int'(micro_addr), int'(jogador));
        active = 1'b1;
        d      = 1;
      end
    end
  end

  logic [3:0] last_we_addr = '0;
  logic [1:0] last_we_data = '0;
  bit         we_seen = 1'b0;

  always @(negedge clock) begin
    logic [3:0] e_st;
    logic       e_we, e_pr, e_inv;
    logic [1:0] e_data;
    if (started) begin
      e_st = 4'd0; e_we = 1'b0; e_pr = 1'b0; e_inv = 1'b0; e_data = 2'b00;
      if (active) begin
        if (d == 1) e_st = 4'd1;
        else if (!op_valid) begin e_st = 4'd6; e_inv = 1'b1; end
        else if (d == 2) e_st = 4'd2;
        else if (d <= 10) e_st = 4'd3;
        else if (d == 11) begin
          e_st = 4'd4; e_data = op_outcome; e_we = op_outcome != 2'b00;
          check("wr_addr", macro_wr_addr, op_macro);
        end else begin e_st = 4'd5; e_pr = 1'b1; end
      end
      check("db_estado", db_estado, e_st);
      check("ocupado", ocupado, active);
      check("macro_we", macro_we, e_we);
      check("macro_wr_data", macro_wr_data, e_data);
      check("pronto", pronto, e_pr);
      check("jogada_invalida", jogada_invalida, e_inv);
      check("resultado_micro", resultado_micro, shown_result);
      if (macro_we) begin
        last_we_addr = macro_wr_addr;
        last_we_data = macro_wr_data;
        we_seen      = 1'b1;
      end
    end
  end

  task automatic issue(input int mac, input int mic, input int pl);
    @(posedge clock); #2;
    macro_addr = mac[3:0];
    micro_addr = mic[3:0];
    jogador    = pl[0];
    commit     = 1'b1;
    @(posedge clock); #2;
    commit = 1'b0;
  endtask

  // Issue one move and check the cycle at which pronto/jogada_invalida shows up.
  task automatic play(input int mac, input int mic, input int pl, input int exp_lat, input string name);
    int lat;
    issue(mac, mic, pl);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (pronto || jogada_invalida) begin lat = n; break; end
    end
    check(name, lat, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("reset_estado", db_estado, 4'd0);
    check("reset_result", resultado_micro, 2'b00);

    // X wins macro 4 on the top row, O plays in macro 0 in between.
    play(4, 0, 0, 12, "lat_x4_0");
    play(0, 0, 1, 12, "lat_o0_0");
    play(4, 1, 0, 12, "lat_x4_1");
    play(0, 1, 1, 12, "lat_o0_1");
    play(4, 2, 0, 12, "lat_x4_2");
    check("xwin_addr", last_we_addr, 4'd4);
    check("xwin_data", last_we_data, 2'b01);
    check("xwin_result", resultado_micro, 2'b01);

    // Decided macro rejects further moves.
    we_seen = 1'b0;
    play(4, 5, 1, 2, "lat_decided_reject");
    check("decided_no_we", we_seen, 1'b0);

    // Macro 2 fills up with no line: draw.
    play(2, 0, 0, 12, "m2_x0"); play(2, 1, 1, 12, "m2_o1");
    play(2, 2, 0, 12, "m2_x2"); play(2, 4, 1, 12, "m2_o4");
    play(2, 3, 0, 12, "m2_x3"); play(2, 5, 1, 12, "m2_o5");
    play(2, 7, 0, 12, "m2_x7"); play(2, 6, 1, 12, "m2_o6");
    play(2, 8, 0, 12, "m2_x8");
    check("draw_addr", last_we_addr, 4'd2);
    check("draw_data", last_we_data, 2'b11);
    check("draw_result", resultado_micro, 2'b11);

    // Macro 6: ninth mark closes the 2-4-6 diagonal for O, so win beats draw.
    play(6, 0, 0, 12, "m6_x0"); play(6, 3, 1, 12, "m6_o3");
    play(6, 1, 0, 12, "m6_x1"); play(6, 4, 1, 12, "m6_o4");
    play(6, 5, 0, 12, "m6_x5"); play(6, 6, 1, 12, "m6_o6");
    play(6, 7, 0, 12, "m6_x7"); play(6, 8, 0, 12, "m6_x8");
    play(6, 2, 1, 12, "m6_o2");
    check("owin_addr", last_we_addr, 4'd6);
    check("owin_data", last_we_data, 2'b10);
    check("owin_result", resultado_micro, 2'b10);

    // Occupied cell, micro out of range, macro out of range.
    we_seen = 1'b0;
    play(0, 0, 0, 2, "lat_occupied");
    play(1, 9, 0, 2, "lat_micro9");
    play(12, 0, 0, 2, "lat_macro12");
    check("reject_no_we", we_seen, 1'b0);
    check("reject_keeps_result", resultado_micro, 2'b10);

    // A commit during SCAN is ignored; its cell stays free for a later move.
    issue(1, 0, 0);
    repeat (4) @(posedge clock);
    #2; macro_addr = 4'd1; micro_addr = 4'd1; jogador = 1'b1; commit = 1'b1;
    @(posedge clock); #2 commit = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (pronto) break;
    end
    check("scan_commit_pronto", pronto, 1'b1);
    play(1, 1, 1, 12, "lat_after_scan_commit");

    // Reset during SCAN: back to idle, outputs cleared, the same cell replays.
    issue(1, 4, 0);
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    @(negedge clock);
    check("rst_scan_estado", db_estado, 4'd0);
    check("rst_scan_busy", ocupado, 1'b0);
    play(1, 4, 0, 12, "lat_replay_after_reset");
    play(0, 0, 0, 12, "lat_cleared_cell");
    play(4, 5, 1, 12, "lat_cleared_decided");

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
